// File: rtl/rega_pkg.sv
// Shared state encodings and default timing parameters for the irrigation sequencer.
package rega_pkg;

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        GOTEJANDO  = 3'd1,
        ASPERSANDO = 3'd2,
        PAUSA      = 3'd3,
        FALHA      = 3'd4
    } estado_t;

    localparam int TICK_DIV_DEF    = 50000;
    localparam int MIN_ON_DEF      = 10;
    localparam int MIN_OFF_DEF     = 5;
    localparam int BLINK_TICKS_DEF = 250;

    localparam logic [15:0] TEMPO_MAX = 16'hFFFF;

endpackage

// File: rtl/sincronizador_entrada.sv
// Two-flop synchronizer for one asynchronous input; 2-cycle latency, no backpressure.
module sincronizador_entrada (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/sequenciador_rega.sv
// Irrigation pump sequencer: drip/sprinkler runs with minimum on/off times and fault latch.
// Input change reaches the registered outputs at the 3rd clock edge; no backpressure.
module sequenciador_rega
    import rega_pkg::*;
#(
    parameter int TICK_DIV    = TICK_DIV_DEF,
    parameter int MIN_ON      = MIN_ON_DEF,
    parameter int MIN_OFF     = MIN_OFF_DEF,
    parameter int BLINK_TICKS = BLINK_TICKS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gotejamento,
    input  logic       aspersao,
    input  logic       valvulaEntrada,
    input  logic       erro,
    input  logic       alarme,
    input  logic       reconhecer,
    output logic       bombaGotejamento,
    output logic       bombaAspersao,
    output logic       valvulaSaida,
    output logic       sirene,
    output logic [2:0] estado
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic w_gotejamento_s, w_aspersao_s, w_valvulaEntrada_s;
    logic w_erro_s, w_alarme_s, w_reconhecer_s;

    sincronizador_entrada u_sync_got (.clk(clk), .reset(reset), .i_async(gotejamento),    .o_sync(w_gotejamento_s));
    sincronizador_entrada u_sync_asp (.clk(clk), .reset(reset), .i_async(aspersao),       .o_sync(w_aspersao_s));
    sincronizador_entrada u_sync_val (.clk(clk), .reset(reset), .i_async(valvulaEntrada), .o_sync(w_valvulaEntrada_s));
    sincronizador_entrada u_sync_err (.clk(clk), .reset(reset), .i_async(erro),           .o_sync(w_erro_s));
    sincronizador_entrada u_sync_alm (.clk(clk), .reset(reset), .i_async(alarme),         .o_sync(w_alarme_s));
    sincronizador_entrada u_sync_rec (.clk(clk), .reset(reset), .i_async(reconhecer),     .o_sync(w_reconhecer_s));

    logic [PW-1:0] r_presc;
    logic          w_tick;
    estado_t       r_state, w_next;
    logic [15:0]   r_tempo;
    logic          r_reconhecer_d;
    logic          w_rec_rise;
    logic [BW-1:0] r_blink_cnt, w_blink_cnt_nxt;
    logic          r_blink, w_blink_nxt;
    logic          w_blink_en;
    logic          r_bomba_got, r_bomba_asp, r_valvula, r_sirene;

    assign w_tick = (r_presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || w_tick) r_presc <= '0;
        else                 r_presc <= r_presc + 1'b1;
    end

    assign w_rec_rise = w_reconhecer_s & ~r_reconhecer_d;

    // Fault and alarm exits ignore MIN_ON; a run never hops directly between pumps.
    always_comb begin
        w_next = r_state;
        case (r_state)
            OCIOSO: begin
                if (w_erro_s)             w_next = FALHA;
                else if (w_aspersao_s)    w_next = ASPERSANDO;
                else if (w_gotejamento_s) w_next = GOTEJANDO;
            end
            GOTEJANDO: begin
                if (w_erro_s)        w_next = FALHA;
                else if (w_alarme_s) w_next = PAUSA;
                else if (!w_gotejamento_s && r_tempo >= 16'(MIN_ON)) w_next = PAUSA;
            end
            ASPERSANDO: begin
                if (w_erro_s)        w_next = FALHA;
                else if (w_alarme_s) w_next = PAUSA;
                else if (!w_aspersao_s && r_tempo >= 16'(MIN_ON)) w_next = PAUSA;
            end
            PAUSA: begin
                if (w_erro_s)                      w_next = FALHA;
                else if (r_tempo >= 16'(MIN_OFF))  w_next = OCIOSO;
            end
            FALHA: begin
                if (w_rec_rise && !w_erro_s) w_next = PAUSA;
            end
            default: w_next = OCIOSO;
        endcase
    end

    assign w_blink_en = w_alarme_s && (w_next != FALHA);

    always_comb begin
        w_blink_cnt_nxt = r_blink_cnt;
        w_blink_nxt     = r_blink;
        if (!w_blink_en) begin
            w_blink_cnt_nxt = '0;
            w_blink_nxt     = 1'b0;
        end else if (w_tick) begin
            if (r_blink_cnt == BW'(BLINK_TICKS - 1)) begin
                w_blink_cnt_nxt = '0;
                w_blink_nxt     = ~r_blink;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + 1'b1;
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= OCIOSO;
            r_tempo        <= '0;
            r_reconhecer_d <= 1'b0;
            r_blink_cnt    <= '0;
            r_blink        <= 1'b0;
            r_bomba_got    <= 1'b0;
            r_bomba_asp    <= 1'b0;
            r_valvula      <= 1'b0;
            r_sirene       <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_reconhecer_d <= w_reconhecer_s;
            r_blink_cnt    <= w_blink_cnt_nxt;
            r_blink        <= w_blink_nxt;
            if (w_next != r_state)
                r_tempo <= '0;
            else if (w_tick && r_tempo != TEMPO_MAX)
                r_tempo <= r_tempo + 16'd1;
            r_bomba_got <= (w_next == GOTEJANDO);
            r_bomba_asp <= (w_next == ASPERSANDO);
            r_valvula   <= w_valvulaEntrada_s && (w_next != FALHA);
            r_sirene    <= (w_next == FALHA) || w_blink_nxt;
        end
    end

    assign bombaGotejamento = r_bomba_got;
    assign bombaAspersao    = r_bomba_asp;
    assign valvulaSaida     = r_valvula;
    assign sirene           = r_sirene;
    assign estado           = r_state;

endmodule
